// File: rtl/store_merge_unit_if.sv
// Word-addressed memory port between the store merge unit and memory.
// The unit holds Mem_Rd or Mem_Wr plus address/data stable until Mem_Ready is sampled high.
interface store_merge_unit_if;
  logic [31:0] Mem_Addr;
  logic        Mem_Rd;
  logic        Mem_Wr;
  logic [31:0] Mem_WData;
  logic [31:0] Mem_RData;
  logic        Mem_Ready;

  modport master (
    output Mem_Addr, Mem_Rd, Mem_Wr, Mem_WData,
    input  Mem_RData, Mem_Ready
  );

  modport slave (
    input  Mem_Addr, Mem_Rd, Mem_Wr, Mem_WData,
    output Mem_RData, Mem_Ready
  );
endinterface

// File: rtl/store_merge_unit.sv
// Narrows register store data into byte/halfword lanes of a word-only memory.
// SB/SH use read-modify-write, SW writes directly; Busy holds the datapath until Done or Err.
module store_merge_unit #(
  parameter int MAX_WAIT = 255,
  parameter int WAIT_W   = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                Start,
  input  logic [1:0]          Size,
  input  logic [31:0]         Addr,
  input  logic [31:0]         WData,
  store_merge_unit_if.master  mem,
  output logic                Busy,
  output logic                Done,
  output logic                Err,
  output logic [2:0]          o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD    = 3'd1,
    S_MERGE = 3'd2,
    S_WR    = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  state_t              r_state;
  logic [1:0]          r_size;
  logic [31:0]         r_addr;
  logic [31:0]         r_wdata;
  logic [31:0]         r_rdata;
  logic [31:0]         r_mem_wdata;
  logic                r_mem_rd;
  logic                r_mem_wr;
  logic                r_busy;
  logic                r_done;
  logic                r_err;
  logic [WAIT_W-1:0]   r_wait;

  logic                w_misaligned;
  logic [31:0]         w_merged;

  assign w_misaligned = (Size == 2'b11) ||
                        (Size == 2'b00 && Addr[1:0] != 2'b00) ||
                        (Size == 2'b01 && Addr[0]);

  always_comb begin
    w_merged = r_rdata;
    if (r_size == 2'b00) begin
      w_merged = r_wdata;
    end else if (r_size == 2'b10) begin
      case (r_addr[1:0])
        2'd0:    w_merged[7:0]   = r_wdata[7:0];
        2'd1:    w_merged[15:8]  = r_wdata[7:0];
        2'd2:    w_merged[23:16] = r_wdata[7:0];
        default: w_merged[31:24] = r_wdata[7:0];
      endcase
    end else if (r_addr[1]) begin
      w_merged[31:16] = r_wdata[15:0];
    end else begin
      w_merged[15:0] = r_wdata[15:0];
    end
  end

  // A request (Mem_Rd or Mem_Wr) is a level held with stable address/data until the
  // cycle Mem_Ready=1 is sampled; it drops the next cycle. Ready in any other state is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_size      <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_mem_wdata <= '0;
      r_mem_rd    <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_wait      <= '0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (Start) begin
            r_size  <= Size;
            r_addr  <= Addr;
            r_wdata <= WData;
            r_busy  <= 1'b1;
            r_wait  <= '0;
            if (w_misaligned) begin
              r_err   <= 1'b1;
              r_state <= S_ERR;
            end else if (Size == 2'b00) begin
              r_mem_wdata <= WData;
              r_mem_wr    <= 1'b1;
              r_state     <= S_WR;
            end else begin
              r_mem_rd <= 1'b1;
              r_state  <= S_RD;
            end
          end
        end
        S_RD: begin
          if (mem.Mem_Ready) begin
            r_rdata  <= mem.Mem_RData;
            r_mem_rd <= 1'b0;
            r_state  <= S_MERGE;
          end else if (r_wait == WAIT_LAST) begin
            r_mem_rd <= 1'b0;
            r_err    <= 1'b1;
            r_state  <= S_ERR;
          end else begin
            r_wait <= r_wait + WAIT_W'(1);
          end
        end
        S_MERGE: begin
          r_mem_wdata <= w_merged;
          r_mem_wr    <= 1'b1;
          r_wait      <= '0;
          r_state     <= S_WR;
        end
        S_WR: begin
          if (mem.Mem_Ready) begin
            r_mem_wr <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end else if (r_wait == WAIT_LAST) begin
            r_mem_wr <= 1'b0;
            r_err    <= 1'b1;
            r_state  <= S_ERR;
          end else begin
            r_wait <= r_wait + WAIT_W'(1);
          end
        end
        S_DONE, S_ERR: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy   <= 1'b0;
          r_mem_rd <= 1'b0;
          r_mem_wr <= 1'b0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

  assign mem.Mem_Addr  = {r_addr[31:2], 2'b00};
  assign mem.Mem_Rd    = r_mem_rd;
  assign mem.Mem_Wr    = r_mem_wr;
  assign mem.Mem_WData = r_mem_wdata;
  assign Busy          = r_busy;
  assign Done          = r_done;
  assign Err           = r_err;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_store_merge_unit.sv
// Directed bench for store_merge_unit: vector table plus stall, timeout and reset sequences.
module tb_store_merge_unit;

  logic        clk;
  logic        rst_n;
  logic        Start;
  logic [1:0]  Size;
  logic [31:0] Addr;
  logic [31:0] WData;
  logic        Busy;
  logic        Done;
  logic        Err;
  logic [2:0]  o_dbg_state;

  store_merge_unit_if mem ();

  store_merge_unit #(.MAX_WAIT(255), .WAIT_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .Start       (Start),
    .Size        (Size),
    .Addr        (Addr),
    .WData       (WData),
    .mem         (mem.master),
    .Busy        (Busy),
    .Done        (Done),
    .Err         (Err),
    .o_dbg_state (o_dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total;
  int n_pass;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // per-transaction observations
  int          rd_cnt, wr_cnt, busy_cnt, done_cnt, err_cnt, done_cyc, err_cyc;
  logic [31:0] rd_addr, wr_addr, wr_data;
  bit          unstable, overlap, hung;

  task automatic run_txn(input logic [1:0] sz, input logic [31:0] ad, input logic [31:0] wd,
                         input logic [31:0] rd, input int rd_hold, input int wr_hold,
                         input bit spam);
    int  k;
    bit  ended;
    rd_cnt = 0; wr_cnt = 0; busy_cnt = 0; done_cnt = 0; err_cnt = 0;
    done_cyc = 0; err_cyc = 0; rd_addr = '0; wr_addr = '0; wr_data = '0;
    unstable = 0; overlap = 0; hung = 0;
    @(negedge clk);
    Size = sz; Addr = ad; WData = wd; mem.Mem_RData = rd; mem.Mem_Ready = 1'b1; Start = 1'b1;
    k = 0; ended = 0;
    while (!ended && k < 400) begin
      @(posedge clk); #1;
      k++;
      Start = 1'b0;
      if (spam) begin
        Size  = 2'($urandom_range(0, 3));
        Addr  = $urandom;
        WData = $urandom;
      end
      if (mem.Mem_Rd) begin
        rd_cnt++;
        if (rd_cnt == 1) rd_addr = mem.Mem_Addr;
        else if (mem.Mem_Addr !== rd_addr) unstable = 1;
      end
      if (mem.Mem_Wr) begin
        wr_cnt++;
        if (wr_cnt == 1) begin wr_addr = mem.Mem_Addr; wr_data = mem.Mem_WData; end
        else if (mem.Mem_Addr !== wr_addr || mem.Mem_WData !== wr_data) unstable = 1;
      end
      if (mem.Mem_Rd && mem.Mem_Wr) overlap = 1;
      if (Busy) busy_cnt++;
      if (Done) begin done_cnt++; done_cyc = k; end
      if (Err)  begin err_cnt++;  err_cyc  = k; end
      if (!Busy) ended = 1;
      mem.Mem_Ready = mem.Mem_Rd ? (rd_cnt > rd_hold) :
                      mem.Mem_Wr ? (wr_cnt > wr_hold) : 1'b1;
      if (spam && Busy && !Done && !Err) Start = 1'b1;
    end
    Start = 1'b0;
    hung = !ended;
  endtask

  typedef struct {
    string       name;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          exp_rd;
    int          exp_wr;
    logic [31:0] exp_waddr;
    logic [31:0] exp_wdata;
    bit          exp_err;
    int          exp_end;
  } vec_t;

  vec_t vecs[10];

  initial begin
    n_total = 0; n_pass = 0;
    vecs[0] = '{"sw_104",    2'b00, 32'h0000_0104, 32'hDEAD_BEEF, 32'h0000_0000, 0, 1, 32'h104, 32'hDEAD_BEEF, 0, 2};
    vecs[1] = '{"sb_202",    2'b10, 32'h0000_0202, 32'h0000_00A5, 32'h1122_3344, 1, 1, 32'h200, 32'h11A5_3344, 0, 4};
    vecs[2] = '{"sh_12",     2'b01, 32'h0000_0012, 32'hFFFF_BEEF, 32'h1122_3344, 1, 1, 32'h010, 32'hBEEF_3344, 0, 4};
    vecs[3] = '{"sh_10",     2'b01, 32'h0000_0010, 32'hFFFF_BEEF, 32'h1122_3344, 1, 1, 32'h010, 32'h1122_BEEF, 0, 4};
    vecs[4] = '{"sb_203",    2'b10, 32'h0000_0203, 32'h0000_0077, 32'h1122_3344, 1, 1, 32'h200, 32'h7722_3344, 0, 4};
    vecs[5] = '{"sb_200",    2'b10, 32'h0000_0200, 32'h1234_5699, 32'h1122_3344, 1, 1, 32'h200, 32'h1122_3399, 0, 4};
    vecs[6] = '{"sb_401",    2'b10, 32'h0000_0401, 32'h0000_005A, 32'hAABB_CCDD, 1, 1, 32'h400, 32'hAABB_5ADD, 0, 4};
    vecs[7] = '{"sh_11_mis", 2'b01, 32'h0000_0011, 32'h0000_1234, 32'h1122_3344, 0, 0, 32'h0,   32'h0,         1, 1};
    vecs[8] = '{"sw_2_mis",  2'b00, 32'h0000_0002, 32'h0000_1234, 32'h1122_3344, 0, 0, 32'h0,   32'h0,         1, 1};
    vecs[9] = '{"sz11_mis",  2'b11, 32'h0000_0100, 32'h0000_1234, 32'h1122_3344, 0, 0, 32'h0,   32'h0,         1, 1};

    rst_n = 1'b0; Start = 1'b0; Size = '0; Addr = '0; WData = '0;
    mem.Mem_RData = '0; mem.Mem_Ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", {29'd0, o_dbg_state}, 32'd0);
    chk("reset_ctrl",  {27'd0, Busy, Done, Err, mem.Mem_Rd, mem.Mem_Wr}, 32'd0);
    chk("reset_addr",  mem.Mem_Addr, 32'd0);
    chk("reset_wdata", mem.Mem_WData, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      run_txn(vecs[i].size, vecs[i].addr, vecs[i].wdata, vecs[i].rdata, 0, 0, 0);
      chk({vecs[i].name, "_hung"},    32'(hung), 32'd0);
      chk({vecs[i].name, "_rd_cnt"},  rd_cnt, vecs[i].exp_rd);
      chk({vecs[i].name, "_wr_cnt"},  wr_cnt, vecs[i].exp_wr);
      chk({vecs[i].name, "_overlap"}, 32'(overlap), 32'd0);
      chk({vecs[i].name, "_busy"},    busy_cnt, vecs[i].exp_end);
      if (vecs[i].exp_err) begin
        chk({vecs[i].name, "_err_cyc"}, err_cyc, vecs[i].exp_end);
        chk({vecs[i].name, "_err_cnt"}, err_cnt, 1);
        chk({vecs[i].name, "_done_cnt"}, done_cnt, 0);
      end else begin
        chk({vecs[i].name, "_done_cyc"}, done_cyc, vecs[i].exp_end);
        chk({vecs[i].name, "_done_cnt"}, done_cnt, 1);
        chk({vecs[i].name, "_err_cnt"},  err_cnt, 0);
        chk({vecs[i].name, "_waddr"},    wr_addr, vecs[i].exp_waddr);
        chk({vecs[i].name, "_wdata"},    wr_data, vecs[i].exp_wdata);
        if (vecs[i].exp_rd != 0) chk({vecs[i].name, "_raddr"}, rd_addr, vecs[i].exp_waddr);
      end
    end

    // stalled SB: 3 wait cycles in RD, 2 in WR, Start spammed while busy
    run_txn(2'b10, 32'h0000_0202, 32'h0000_00A5, 32'h1122_3344, 3, 2, 1);
    chk("stall_hung",     32'(hung), 32'd0);
    chk("stall_rd_cnt",   rd_cnt, 4);
    chk("stall_wr_cnt",   wr_cnt, 3);
    chk("stall_stable",   32'(unstable), 32'd0);
    chk("stall_waddr",    wr_addr, 32'h0000_0200);
    chk("stall_wdata",    wr_data, 32'h11A5_3344);
    chk("stall_done_cyc", done_cyc, 9);
    chk("stall_busy",     busy_cnt, 9);
    chk("stall_done_cnt", done_cnt, 1);

    // Mem_Ready stuck low in RD
    run_txn(2'b01, 32'h0000_0020, 32'h0000_ABCD, 32'h1122_3344, 100000, 0, 0);
    chk("tmo_hung",    32'(hung), 32'd0);
    chk("tmo_rd_cnt",  rd_cnt, 255);
    chk("tmo_wr_cnt",  wr_cnt, 0);
    chk("tmo_err_cyc", err_cyc, 256);
    chk("tmo_err_cnt", err_cnt, 1);
    chk("tmo_done",    done_cnt, 0);

    // reset asserted while WR is pending
    begin
      int  k;
      bit  wr_seen;
      bit  wr_after;
      @(negedge clk);
      Size = 2'b10; Addr = 32'h0000_0301; WData = 32'h0000_0042;
      mem.Mem_RData = 32'h5566_7788; mem.Mem_Ready = 1'b1; Start = 1'b1;
      k = 0; wr_seen = 0; wr_after = 0;
      while (!wr_seen && k < 20) begin
        @(posedge clk); #1;
        k++;
        Start = 1'b0;
        mem.Mem_Ready = mem.Mem_Rd;
        if (mem.Mem_Wr) wr_seen = 1;
      end
      chk("rst_wr_reached", 32'(wr_seen), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_mid_state", {29'd0, o_dbg_state}, 32'd0);
      chk("rst_mid_ctrl",  {27'd0, Busy, Done, Err, mem.Mem_Rd, mem.Mem_Wr}, 32'd0);
      chk("rst_mid_addr",  mem.Mem_Addr, 32'd0);
      chk("rst_mid_wdata", mem.Mem_WData, 32'd0);
      mem.Mem_Ready = 1'b1;
      repeat (3) begin
        @(posedge clk); #1;
        if (mem.Mem_Wr) wr_after = 1;
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) begin
        @(posedge clk); #1;
        if (mem.Mem_Wr || Busy) wr_after = 1;
      end
      chk("rst_no_wr", 32'(wr_after), 32'd0);
    end

    // recovery after reset
    run_txn(2'b00, 32'h0000_0F00, 32'hCAFE_F00D, 32'h0, 0, 0, 0);
    chk("post_rst_done_cyc", done_cyc, 2);
    chk("post_rst_wdata",    wr_data, 32'hCAFE_F00D);
    chk("post_rst_waddr",    wr_addr, 32'h0000_0F00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
